// File: rtl/alu_pkg.sv
// Shared ALU types: op encoding, NZCV flag struct and flag bit positions.
// No logic, so it has no latency.
// No handshake, so it has no backpressure.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_PASS = 2'd0,
        OP_SHL  = 2'd1,
        OP_SHR  = 2'd2,
        OP_SAR  = 2'd3
    } op_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_skid_buffer.sv
// Generic 2-entry valid/ready skid buffer for any payload type T.
// Latency: 1 cycle from input to output.
// Backpressure: in_ready is a flop output that drops only when both entries are held.
module alu_skid_buffer #(
    parameter type T = logic [7:0]
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

    // The encoding is {main valid, skid valid}, so both flags come straight off the state flops.
    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_ONE   = 2'b10,
        S_FULL  = 2'b11
    } state_e;

    state_e state;
    T       main_dat;
    T       skid_dat;
    logic   acc;
    logic   emit;

    assign in_ready  = ~state[0];
    assign out_valid = state[1];
    assign out_data  = main_dat;
    assign acc       = in_valid & ~state[0];
    assign emit      = state[1] & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_EMPTY;
            main_dat <= '0;
            skid_dat <= '0;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (acc) begin
                        main_dat <= in_data;
                        state    <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (acc && emit) begin
                        main_dat <= in_data;
                    end else if (acc) begin
                        skid_dat <= in_data;
                        state    <= S_FULL;
                    end else if (emit) begin
                        state    <= S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (emit) begin
                        main_dat <= skid_dat;
                        state    <= S_ONE;
                    end
                end
                default: state <= S_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result/NZCV flag stage into writeback; ALU_STICKY_FLAGS_EN adds sticky {C,V}.
// Latency: 1 cycle from input to out_valid.
// Backpressure: 2-entry skid buffer, in_ready is registered and drops only when full.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_carry,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_flags,
    input  logic             flag_clr,
    output logic [1:0]       sticky_cv
);

    typedef struct packed {
        logic [WIDTH-1:0] result;
        flags_t           flags;
    } entry_t;

    entry_t in_entry;
    entry_t out_entry;

    always_comb begin
        in_entry        = '0;
        in_entry.result = in_result;
        in_entry.flags.n = in_result[WIDTH-1];
        in_entry.flags.z = (in_result == '0);
        in_entry.flags.c = in_carry;
        // Overflow on a left shift means the sign bit changed as it left.
        in_entry.flags.v = (op_e'(in_op) == OP_SHL) ? (in_carry ^ in_result[WIDTH-1]) : 1'b0;
    end

    alu_skid_buffer #(
        .T (entry_t)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_entry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_entry)
    );

    assign out_result = out_entry.result;
    assign out_flags  = out_entry.flags;

`ifdef ALU_STICKY_FLAGS_EN
    logic [1:0] cv_new;

    assign cv_new = (out_valid && out_ready) ?
                    {out_entry.flags.c, out_entry.flags.v} : 2'b00;

    // A clear in an emitting cycle still keeps that word's own C/V.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_cv <= 2'b00;
        end else begin
            sticky_cv <= flag_clr ? cv_new : (sticky_cv | cv_new);
        end
    end
`else
    logic unused_flag_clr;

    assign unused_flag_clr = flag_clr;
    assign sticky_cv       = 2'b00;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage (WIDTH=4): reset, flags, backpressure, throughput, sticky flags.
module tb_alu_result_stage;
    import alu_pkg::*;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_result;
    logic             in_carry;
    logic [1:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [3:0]       out_flags;
    logic             flag_clr;
    logic [1:0]       sticky_cv;

    int total;
    int bad;

    alu_result_stage #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_carry   (in_carry),
        .in_op      (in_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags),
        .flag_clr   (flag_clr),
        .sticky_cv  (sticky_cv)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Sends one word with out_ready=1, checks it one cycle later, then lets it emit.
    task automatic send_one(input string tag, input logic [3:0] res, input logic cy,
                            input logic [1:0] op, input logic clr, input logic [3:0] exp_flags);
        in_valid  = 1'b1;
        in_result = res;
        in_carry  = cy;
        in_op     = op;
        out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_vld"}, 32'(out_valid), 32'd1);
        chk({tag, "_res"}, 32'(out_result), 32'(res));
        chk({tag, "_flags"}, 32'(out_flags), 32'(exp_flags));
        in_valid = 1'b0;
        flag_clr = clr;
        @(negedge clk);
        flag_clr = 1'b0;
        chk({tag, "_gone"}, 32'(out_valid), 32'd0);
    endtask

    logic [1:0] exp_sticky;

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_result = 4'b0101;
        in_carry  = 1'b1;
        in_op     = OP_PASS;
        out_ready = 1'b0;
        flag_clr  = 1'b0;

        // 1. Reset held with in_valid high
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_flags", 32'(out_flags), 32'd0);
        chk("rst_out_result", 32'(out_result), 32'd0);
        chk("rst_sticky", 32'(sticky_cv), 32'd0);
        rst_n     = 1'b1;
        in_carry  = 1'b0;
        @(negedge clk);
        chk("first_vld", 32'(out_valid), 32'd1);
        chk("first_res", 32'(out_result), 32'h5);
        chk("first_flags", 32'(out_flags), 32'h0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("first_gone", 32'(out_valid), 32'd0);

        // 2. Flag computation
        send_one("shr_zero", 4'b0000, 1'b0, OP_SHR, 1'b0, 4'b0100);
        send_one("shr_carry", 4'b0000, 1'b1, OP_SHR, 1'b0, 4'b0110);
        send_one("shl_ovf", 4'b1000, 1'b0, OP_SHL, 1'b0, 4'b1001);
        send_one("sar_neg", 4'b1110, 1'b1, OP_SAR, 1'b0, 4'b1010);

        // 3. Backpressure: fill both entries, ignore a third offer, then drain in order
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = OP_PASS;
        in_carry  = 1'b0;
        in_result = 4'b0001;
        @(negedge clk);
        chk("bp_rdy_one", 32'(in_ready), 32'd1);
        in_result = 4'b0010;
        @(negedge clk);
        chk("bp_rdy_full", 32'(in_ready), 32'd0);
        chk("bp_head", 32'(out_result), 32'h1);
        in_result = 4'b0011;
        @(negedge clk);
        chk("bp_rdy_hold", 32'(in_ready), 32'd0);
        chk("bp_stable", 32'(out_result), 32'h1);
        chk("bp_stable_vld", 32'(out_valid), 32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_second", 32'(out_result), 32'h2);
        chk("bp_second_vld", 32'(out_valid), 32'd1);
        chk("bp_rdy_back", 32'(in_ready), 32'd1);
        @(negedge clk);
        chk("bp_drained", 32'(out_valid), 32'd0);

        // 4. Throughput: one word per cycle in and out
        out_ready = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            if (i > 0) begin
                chk("tp_vld", 32'(out_valid), 32'd1);
                chk("tp_res", 32'(out_result), 32'(i - 1));
            end
            chk("tp_rdy", 32'(in_ready), 32'd1);
            if (i < 8) begin
                in_valid  = 1'b1;
                in_result = 4'(i);
            end else begin
                in_valid  = 1'b0;
            end
            @(negedge clk);
        end
        chk("tp_done", 32'(out_valid), 32'd0);

        // 5. Reset while full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_result = 4'b1010;
        @(negedge clk);
        in_result = 4'b1011;
        @(negedge clk);
        in_valid = 1'b0;
        chk("rf_full", 32'(in_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("rf_vld_now", 32'(out_valid), 32'd0);
        chk("rf_rdy_now", 32'(in_ready), 32'd1);
        chk("rf_res_now", 32'(out_result), 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rf_no_stale", 32'(out_valid), 32'd0);
        end
        send_one("rf_after", 4'b0110, 1'b0, OP_PASS, 1'b0, 4'b0000);
        chk("rf_sticky", 32'(sticky_cv), 32'd0);

        // 6. Sticky C/V
`ifdef ALU_STICKY_FLAGS_EN
        exp_sticky = 2'b10;
`else
        exp_sticky = 2'b00;
`endif
        send_one("st_shr", 4'b0000, 1'b1, OP_SHR, 1'b0, 4'b0110);
        chk("st_after_shr", 32'(sticky_cv), 32'(exp_sticky));
        send_one("st_pass", 4'b0011, 1'b0, OP_PASS, 1'b0, 4'b0000);
        chk("st_after_pass", 32'(sticky_cv), 32'(exp_sticky));
        send_one("st_clr", 4'b0011, 1'b0, OP_PASS, 1'b1, 4'b0000);
        chk("st_after_clr", 32'(sticky_cv), 32'd0);
`ifdef ALU_STICKY_FLAGS_EN
        exp_sticky = 2'b11;
`endif
        send_one("st_shl", 4'b0100, 1'b1, OP_SHL, 1'b0, 4'b0011);
        chk("st_after_shl", 32'(sticky_cv), 32'(exp_sticky));
`ifdef ALU_STICKY_FLAGS_EN
        exp_sticky = 2'b01;
`endif
        send_one("st_clr_emit", 4'b1000, 1'b0, OP_SHL, 1'b1, 4'b1001);
        chk("st_after_clr_emit", 32'(sticky_cv), 32'(exp_sticky));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
